// File: rtl/life_gen_scheduler_if.sv
// Request/done handshake between the generation scheduler and the RegArray update engine.
// gen_req is held high from the start of a generation until the engine answers with a one-cycle gen_done.
interface life_gen_scheduler_if;
  logic gen_req;
  logic gen_done;

  modport master (output gen_req, input gen_done);
  modport slave  (input gen_req, output gen_done);
endinterface

// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation scheduler: run/pause/step control, rate timer, engine handshake, generation counter.
// Optional VBLANK_SYNC_EN: holds each generation start until vertical blanking.
module life_gen_scheduler #(
  parameter int BASE_PERIOD = 262144,
  parameter int PER_W       = 24,
  parameter int GEN_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_run,
  input  logic                 btn_pause,
  input  logic                 btn_step,
  input  logic                 clr,
  input  logic [1:0]           speed_sel,
  input  logic                 vblank,
  life_gen_scheduler_if.master eng,
  output logic                 running,
  output logic                 busy,
  output logic [GEN_CNT_W-1:0] gen_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SYNC  = 2'd2,
    GEN   = 2'd3
  } state_t;

  state_t           state;
  logic [PER_W-1:0] counter;
  logic [PER_W-1:0] load_val;
  logic             gen_req_q;
  logic             pause_pend;
  logic             clr_pend;

  // Bit order for the synchronizer vectors: {clr, step, pause, run}
  logic [3:0] btn_in;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] prev;
  logic [3:0] edges;
  logic       run_e;
  logic       pause_e;
  logic       step_e;
  logic       clr_e;

  assign btn_in  = {clr, btn_step, btn_pause, btn_run};
  assign edges   = sync2 & ~prev;
  assign run_e   = edges[0];
  assign pause_e = edges[1];
  assign step_e  = edges[2];
  assign clr_e   = edges[3];

  assign load_val  = (PER_W'(BASE_PERIOD) << speed_sel) - PER_W'(1);
  assign eng.gen_req = gen_req_q;
  assign dbg_state   = state;

`ifndef VBLANK_SYNC_EN
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      gen_req_q  <= 1'b0;
      busy       <= 1'b0;
      running    <= 1'b0;
      gen_count  <= '0;
      pause_pend <= 1'b0;
      clr_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_e) begin
            gen_count <= '0;
          end else if (!pause_e) begin
            if (run_e) begin
              running <= 1'b1;
              counter <= load_val;
              state   <= ARMED;
            end else if (step_e) begin
`ifdef VBLANK_SYNC_EN
              state     <= SYNC;
`else
              state     <= GEN;
              gen_req_q <= 1'b1;
              busy      <= 1'b1;
`endif
            end
          end
        end

        ARMED: begin
          if (clr_e || pause_e) begin
            running <= 1'b0;
            state   <= IDLE;
            if (clr_e) gen_count <= '0;
          end else if (counter == '0) begin
`ifdef VBLANK_SYNC_EN
            state     <= SYNC;
`else
            state     <= GEN;
            gen_req_q <= 1'b1;
            busy      <= 1'b1;
`endif
          end else begin
            counter <= counter - PER_W'(1);
          end
        end

`ifdef VBLANK_SYNC_EN
        SYNC: begin
          if (clr_e || pause_e) begin
            running <= 1'b0;
            state   <= IDLE;
            if (clr_e) gen_count <= '0;
          end else if (vblank) begin
            state     <= GEN;
            gen_req_q <= 1'b1;
            busy      <= 1'b1;
          end
        end
`endif

        GEN: begin
          // A generation in flight always completes; pause/clr are deferred to gen_done.
          if (eng.gen_done) begin
            gen_req_q  <= 1'b0;
            busy       <= 1'b0;
            pause_pend <= 1'b0;
            clr_pend   <= 1'b0;
            if (clr_pend || clr_e) gen_count <= '0;
            else                   gen_count <= gen_count + GEN_CNT_W'(1);
            if (running && !(pause_pend || clr_pend || pause_e || clr_e)) begin
              counter <= load_val;
              state   <= ARMED;
            end else begin
              running <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            if (pause_e) pause_pend <= 1'b1;
            if (clr_e)   clr_pend   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
